lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: issues one data-bus access per memory instruction,
// holds the pipeline while it is outstanding, and formats store and load data.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ex_mem_alu_res,
    input  logic [31:0] ex_mem_reg2_rdata,
    input  logic [2:0]  ex_mem_mem_access_type,
    input  logic        ex_mem_mem_sign_ext,
    input  logic        ex_mem_reg_wen,
    input  logic [4:0]  ex_mem_reg_waddr,
    output logic        lsu_stall,
    output logic        lsu_wb_wen,
    output logic [4:0]  lsu_wb_waddr,
    output logic [31:0] lsu_wb_data,
    output logic        lsu_misalign,
    output logic        lsu_bus_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_wstrb,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata
);
    localparam logic [2:0] AT_LB = 3'd1, AT_LH = 3'd2, AT_LW = 3'd3;
    localparam logic [2:0] AT_SB = 3'd4, AT_SH = 3'd5, AT_SW = 3'd6;

    localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3;

    localparam int unsigned   CW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_q, wdata_q, result_q;
    logic [2:0]    type_q;
    logic [3:0]    wstrb_q;
    logic [4:0]    waddr_q;
    logic          sext_q, wen_q, we_q, err_q;

    logic          is_load, is_store, sz_half, sz_word, misal, start;
    logic [31:0]   fmt_wdata, shifted, ld_val;
    logic [3:0]    fmt_wstrb;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz_half  = 1'b0;
        sz_word  = 1'b0;
        case (ex_mem_mem_access_type)
            AT_LB: is_load = 1'b1;
            AT_LH: begin is_load = 1'b1; sz_half = 1'b1; end
            AT_LW: begin is_load = 1'b1; sz_word = 1'b1; end
            AT_SB: is_store = 1'b1;
            AT_SH: begin is_store = 1'b1; sz_half = 1'b1; end
            AT_SW: begin is_store = 1'b1; sz_word = 1'b1; end
            default: ;
        endcase
        misal = (sz_half & ex_mem_alu_res[0]) | (sz_word & (ex_mem_alu_res[1:0] != 2'b00));
        start = rst_n && (state == S_IDLE) && (is_load || is_store) && !misal;
    end

    always_comb begin
        fmt_wdata = ex_mem_reg2_rdata;
        fmt_wstrb = 4'b1111;
        if (sz_half) begin
            fmt_wdata = {2{ex_mem_reg2_rdata[15:0]}};
            fmt_wstrb = 4'b0011 << ex_mem_alu_res[1:0];
        end else if (!sz_word) begin
            fmt_wdata = {4{ex_mem_reg2_rdata[7:0]}};
            fmt_wstrb = 4'b0001 << ex_mem_alu_res[1:0];
        end
    end

    assign shifted = dbus_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (type_q)
            AT_LB:   ld_val = {{24{sext_q & shifted[7]}}, shifted[7:0]};
            AT_LH:   ld_val = {{16{sext_q & shifted[15]}}, shifted[15:0]};
            default: ld_val = shifted;
        endcase
    end

    // Timeout wins over a same-cycle gnt/rvalid so an access never exceeds TIMEOUT_CYC bus cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            type_q   <= '0;
            wstrb_q  <= '0;
            waddr_q  <= '0;
            sext_q   <= 1'b0;
            wen_q    <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state   <= S_REQ;
                    cnt     <= '0;
                    err_q   <= 1'b0;
                    addr_q  <= ex_mem_alu_res;
                    type_q  <= ex_mem_mem_access_type;
                    sext_q  <= ex_mem_mem_sign_ext;
                    wen_q   <= ex_mem_reg_wen;
                    waddr_q <= ex_mem_reg_waddr;
                    we_q    <= is_store;
                    wdata_q <= fmt_wdata;
                    wstrb_q <= is_store ? fmt_wstrb : 4'b0000;
                end
                S_REQ: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state <= S_DONE;
                        err_q <= 1'b1;
                    end else if (dbus_gnt) begin
                        state <= we_q ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state <= S_DONE;
                        err_q <= 1'b1;
                    end else if (dbus_rvalid) begin
                        state    <= S_DONE;
                        result_q <= ld_val;
                    end
                end
                S_DONE: state <= S_IDLE;
            endcase
        end
    end

    assign dbus_req    = (state == S_REQ);
    assign dbus_we     = we_q;
    assign dbus_addr   = addr_q;
    assign dbus_wdata  = wdata_q;
    assign dbus_wstrb  = wstrb_q;
    assign lsu_bus_err = (state == S_DONE) & err_q;

    // IDLE decisions are gated by rst_n so outputs stay quiet while reset is held.
    always_comb begin
        lsu_stall    = 1'b0;
        lsu_misalign = 1'b0;
        lsu_wb_wen   = 1'b0;
        lsu_wb_waddr = ex_mem_reg_waddr;
        lsu_wb_data  = ex_mem_alu_res;
        case (state)
            S_IDLE: if (rst_n) begin
                if (!(is_load || is_store)) lsu_wb_wen = ex_mem_reg_wen;
                else if (misal)             lsu_misalign = 1'b1;
                else                        lsu_stall = 1'b1;
            end
            S_REQ, S_WAIT: lsu_stall = 1'b1;
            S_DONE: begin
                lsu_wb_waddr = waddr_q;
                lsu_wb_data  = result_q;
                lsu_wb_wen   = wen_q & ~we_q & ~err_q;
            end
        endcase
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed scenarios plus a randomized instruction stream
// checked against an arithmetic model of the load/store rules.
module tb_lsu_ctrl;
    localparam int unsigned T = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ex_mem_alu_res, ex_mem_reg2_rdata;
    logic [2:0]  ex_mem_mem_access_type;
    logic        ex_mem_mem_sign_ext, ex_mem_reg_wen;
    logic [4:0]  ex_mem_reg_waddr;
    logic        lsu_stall, lsu_wb_wen, lsu_misalign, lsu_bus_err;
    logic [4:0]  lsu_wb_waddr;
    logic [31:0] lsu_wb_data;
    logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_wstrb;

    int unsigned pass_cnt = 0;
    int unsigned chk_cnt  = 0;

    lsu_ctrl #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_mem_alu_res(ex_mem_alu_res), .ex_mem_reg2_rdata(ex_mem_reg2_rdata),
        .ex_mem_mem_access_type(ex_mem_mem_access_type), .ex_mem_mem_sign_ext(ex_mem_mem_sign_ext),
        .ex_mem_reg_wen(ex_mem_reg_wen), .ex_mem_reg_waddr(ex_mem_reg_waddr),
        .lsu_stall(lsu_stall), .lsu_wb_wen(lsu_wb_wen), .lsu_wb_waddr(lsu_wb_waddr),
        .lsu_wb_data(lsu_wb_data), .lsu_misalign(lsu_misalign), .lsu_bus_err(lsu_bus_err),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
        .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
    );

    always #5 clk = ~clk;

    task automatic set_instr(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                             input logic s, input logic w, input logic [4:0] wa);
        ex_mem_mem_access_type = t;
        ex_mem_alu_res         = a;
        ex_mem_reg2_rdata      = d;
        ex_mem_mem_sign_ext    = s;
        ex_mem_reg_wen         = w;
        ex_mem_reg_waddr       = wa;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a,
                                               input logic [31:0] rd, input logic s);
        logic [31:0] sh, v;
        sh = rd >> (8 * (a % 4));
        if (t == 3'd1) begin
            v = sh % 256;
            if (s && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (t == 3'd2) begin
            v = sh % 65536;
            if (s && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] t, input logic [31:0] d);
        if (t == 3'd4) return (d % 256) * 32'h0101_0101;
        if (t == 3'd5) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [2:0] t, input logic [31:0] a);
        if (t == 3'd4) return 4'(1 << (a % 4));
        if (t == 3'd5) return 4'(3 << (a % 4));
        return 4'hF;
    endfunction

    function automatic bit model_misal(input logic [2:0] t, input logic [31:0] a);
        if (t == 3'd2 || t == 3'd5) return (a % 2) != 0;
        if (t == 3'd3 || t == 3'd6) return (a % 4) != 0;
        return 1'b0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        set_instr(3'd3, 32'h0000_0010, 32'hAAAA_5555, 1'b0, 1'b1, 5'd3);
        dbus_gnt = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 32'h1234_5678;
        @(negedge clk);
        chk_cnt++;
        if ({lsu_stall, lsu_wb_wen, lsu_misalign, lsu_bus_err, dbus_req, dbus_we, dbus_wstrb,
             dbus_addr, dbus_wdata} !== 74'd0)
            $display("FAIL reset_outputs got stall=%b wen=%b mis=%b err=%b req=%b we=%b strb=%h addr=%h wd=%h want all 0",
                     lsu_stall, lsu_wb_wen, lsu_misalign, lsu_bus_err, dbus_req, dbus_we, dbus_wstrb, dbus_addr, dbus_wdata);
        else pass_cnt++;
        tick();
        @(negedge clk);
        set_instr(3'd0, 32'hCAFE_0001, 32'h0, 1'b0, 1'b1, 5'd9);
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk_cnt++;
        if ({lsu_stall, lsu_wb_wen, lsu_wb_waddr, lsu_wb_data} !== {1'b0, 1'b1, 5'd9, 32'hCAFE_0001})
            $display("FAIL reset_first_instr got stall=%b wen=%b waddr=%0d data=%h want 0 1 9 cafe0001",
                     lsu_stall, lsu_wb_wen, lsu_wb_waddr, lsu_wb_data);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_passthrough();
        logic [31:0] a;
        logic        w;
        logic [4:0]  wa;
        set_instr(3'd0, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 5'd5);
        @(negedge clk);
        chk_cnt++;
        if ({lsu_stall, lsu_wb_wen, lsu_wb_waddr, lsu_wb_data} !== {1'b0, 1'b1, 5'd5, 32'h1234_5678})
            $display("FAIL none_pass got stall=%b wen=%b waddr=%0d data=%h want 0 1 5 12345678",
                     lsu_stall, lsu_wb_wen, lsu_wb_waddr, lsu_wb_data);
        else pass_cnt++;
        tick();
        for (int i = 0; i < 8; i++) begin
            a = $urandom; w = 1'($urandom_range(0, 1)); wa = 5'($urandom_range(0, 31));
            set_instr((i % 2 == 0) ? 3'd7 : 3'd0, a, $urandom, 1'($urandom_range(0, 1)), w, wa);
            dbus_gnt = 1'($urandom_range(0, 1)); dbus_rvalid = 1'($urandom_range(0, 1)); dbus_rdata = $urandom;
            @(negedge clk);
            chk_cnt++;
            if ({lsu_stall, lsu_misalign, dbus_req, lsu_wb_wen, lsu_wb_waddr, lsu_wb_data} !== {3'b000, w, wa, a})
                $display("FAIL none_rand got stall=%b mis=%b req=%b wen=%b waddr=%0d data=%h want 0 0 0 %b %0d %h",
                         lsu_stall, lsu_misalign, dbus_req, lsu_wb_wen, lsu_wb_waddr, lsu_wb_data, w, wa, a);
            else pass_cnt++;
            tick();
        end
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    endtask

    task automatic test_load_lb();
        int n = 0;
        set_instr(3'd1, 32'h0000_1003, 32'h0, 1'b1, 1'b1, 5'd7);
        dbus_gnt = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 32'h80FF_FFFF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!lsu_stall) break;
            n++;
            tick();
        end
        chk_cnt++;
        if (n != 3) $display("FAIL lb_stall_cycles got %0d want 3", n);
        else pass_cnt++;
        chk_cnt++;
        if ({lsu_wb_wen, lsu_wb_waddr, lsu_wb_data} !== {1'b1, 5'd7, 32'hFFFF_FF80})
            $display("FAIL lb_result got wen=%b waddr=%0d data=%h want 1 7 ffffff80",
                     lsu_wb_wen, lsu_wb_waddr, lsu_wb_data);
        else pass_cnt++;
        tick();
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
        set_instr(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        chk_cnt++;
        if ({lsu_stall, dbus_req} !== 2'b00)
            $display("FAIL lb_no_reissue got stall=%b req=%b want 0 0", lsu_stall, dbus_req);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_store_sh();
        set_instr(3'd5, 32'h0000_2002, 32'h0000_BEEF, 1'b0, 1'b1, 5'd4);
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            dbus_gnt = (k == 2);
            @(negedge clk);
            chk_cnt++;
            if ({dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb, lsu_stall} !==
                {1'b1, 1'b1, 32'h0000_2002, 32'hBEEF_BEEF, 4'b1100, 1'b1})
                $display("FAIL sh_bus got req=%b we=%b addr=%h wd=%h strb=%b stall=%b want 1 1 2002 beefbeef 1100 1",
                         dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb, lsu_stall);
            else pass_cnt++;
            tick();
        end
        dbus_gnt = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({lsu_stall, lsu_wb_wen, dbus_req} !== 3'b000)
            $display("FAIL sh_done got stall=%b wen=%b req=%b want 0 0 0", lsu_stall, lsu_wb_wen, dbus_req);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_misalign();
        logic [2:0]  t;
        logic [31:0] a;
        set_instr(3'd3, 32'h0000_3001, 32'h0, 1'b0, 1'b1, 5'd2);
        dbus_gnt = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                t = (i % 4 == 0) ? 3'd2 : (i % 4 == 1) ? 3'd5 : (i % 4 == 2) ? 3'd3 : 3'd6;
                a = {$urandom, 2'b00} >> 2 << 2;
                a = a + ((t == 3'd2 || t == 3'd5) ? (($urandom_range(0, 1) != 0) ? 32'd1 : 32'd3)
                                                   : 32'($urandom_range(1, 3)));
                set_instr(t, a, $urandom, 1'b0, 1'b1, 5'd2);
            end
            @(negedge clk);
            chk_cnt++;
            if ({lsu_misalign, dbus_req, lsu_stall, lsu_wb_wen} !== 4'b1000)
                $display("FAIL misalign got mis=%b req=%b stall=%b wen=%b want 1 0 0 0 (type %0d addr %h)",
                         lsu_misalign, dbus_req, lsu_stall, lsu_wb_wen, ex_mem_mem_access_type, ex_mem_alu_res);
            else pass_cnt++;
            tick();
            set_instr(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
            @(negedge clk);
            chk_cnt++;
            if ({lsu_misalign, dbus_req, lsu_stall} !== 3'b000)
                $display("FAIL misalign_after got mis=%b req=%b stall=%b want 0 0 0", lsu_misalign, dbus_req, lsu_stall);
            else pass_cnt++;
            tick();
        end
        dbus_gnt = 1'b0;
    endtask

    task automatic test_timeout();
        int n = 0;
        set_instr(3'd2, 32'h0000_4002, 32'h0, 1'b1, 1'b1, 5'd6);
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
        tick();
        for (int k = 0; k < int'(T) + 10; k++) begin
            @(negedge clk);
            if (!(dbus_req && dbus_addr == 32'h0000_4002 && lsu_stall)) break;
            n++;
            tick();
        end
        chk_cnt++;
        if (n != int'(T)) $display("FAIL tmo_req_cycles got %0d want %0d", n, T);
        else pass_cnt++;
        chk_cnt++;
        if ({lsu_bus_err, lsu_wb_wen, lsu_stall, dbus_req} !== 4'b1000)
            $display("FAIL tmo_done got err=%b wen=%b stall=%b req=%b want 1 0 0 0",
                     lsu_bus_err, lsu_wb_wen, lsu_stall, dbus_req);
        else pass_cnt++;
        tick();
        set_instr(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        chk_cnt++;
        if ({lsu_bus_err, lsu_stall, dbus_req} !== 3'b000)
            $display("FAIL tmo_idle got err=%b stall=%b req=%b want 0 0 0", lsu_bus_err, lsu_stall, dbus_req);
        else pass_cnt++;
        tick();
        n = 0;
        set_instr(3'd3, 32'h0000_5000, 32'h0, 1'b0, 1'b1, 5'd8);
        dbus_gnt = 1'b1;
        for (int k = 0; k < int'(T) + 10; k++) begin
            @(negedge clk);
            if (!lsu_stall) break;
            n++;
            tick();
            dbus_gnt = 1'b0;
        end
        chk_cnt++;
        if (n != int'(T) + 1) $display("FAIL tmo_wait_cycles got %0d want %0d", n, T + 1);
        else pass_cnt++;
        chk_cnt++;
        if ({lsu_bus_err, lsu_wb_wen} !== 2'b10)
            $display("FAIL tmo_wait_done got err=%b wen=%b want 1 0", lsu_bus_err, lsu_wb_wen);
        else pass_cnt++;
        tick();
        set_instr(3'd0, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b1, 5'd1);
        dbus_rvalid = 1'b1; dbus_rdata = 32'h7777_7777;
        @(negedge clk);
        chk_cnt++;
        if ({lsu_stall, lsu_bus_err, lsu_wb_wen, lsu_wb_data} !== {3'b001, 32'h0BAD_F00D})
            $display("FAIL tmo_late_rvalid got stall=%b err=%b wen=%b data=%h want 0 0 1 0badf00d",
                     lsu_stall, lsu_bus_err, lsu_wb_wen, lsu_wb_data);
        else pass_cnt++;
        tick();
        dbus_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_instr(3'd1, 32'h0000_6000, 32'h0, 1'b0, 1'b1, 5'd10);
        dbus_gnt = 1'b1; dbus_rvalid = 1'b0;
        tick();
        tick();
        dbus_gnt = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({lsu_stall, dbus_req} !== 2'b10)
            $display("FAIL rstmid_wait got stall=%b req=%b want 1 0", lsu_stall, dbus_req);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({lsu_stall, dbus_req, dbus_we, dbus_wstrb, lsu_bus_err, lsu_wb_wen} !== 9'd0)
            $display("FAIL rstmid_async got stall=%b req=%b we=%b strb=%b err=%b wen=%b want all 0",
                     lsu_stall, dbus_req, dbus_we, dbus_wstrb, lsu_bus_err, lsu_wb_wen);
        else pass_cnt++;
        tick();
        @(negedge clk);
        set_instr(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        dbus_rvalid = 1'b1; dbus_rdata = 32'h5A5A_5A5A;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_cnt++;
            if ({lsu_stall, lsu_wb_wen, dbus_req, lsu_wb_data} !== 35'd0)
                $display("FAIL rstmid_late_rvalid got stall=%b wen=%b req=%b data=%h want 0 0 0 0",
                         lsu_stall, lsu_wb_wen, dbus_req, lsu_wb_data);
            else pass_cnt++;
            tick();
        end
        dbus_rvalid = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0]  t;
        logic [31:0] a, d, rd;
        logic        s, w;
        logic [4:0]  wa;
        int unsigned g, r;
        bit          ld, st;
        for (int i = 0; i < 60; i++) begin
            t = 3'($urandom_range(0, 7)); a = $urandom; d = $urandom; rd = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            s = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1)); wa = 5'($urandom_range(0, 31));
            g = $urandom_range(0, 3); r = $urandom_range(0, 3);
            ld = (t >= 3'd1 && t <= 3'd3);
            st = (t >= 3'd4 && t <= 3'd6);
            set_instr(t, a, d, s, w, wa);
            dbus_gnt = 1'($urandom_range(0, 1)); dbus_rvalid = 1'($urandom_range(0, 1)); dbus_rdata = $urandom;
            @(negedge clk);
            chk_cnt++;
            if (!ld && !st) begin
                if ({lsu_stall, lsu_misalign, dbus_req, lsu_wb_wen, lsu_wb_waddr, lsu_wb_data} !== {3'b000, w, wa, a})
                    $display("FAIL rnd_none got stall=%b wen=%b waddr=%0d data=%h want 0 %b %0d %h",
                             lsu_stall, lsu_wb_wen, lsu_wb_waddr, lsu_wb_data, w, wa, a);
                else pass_cnt++;
                tick();
            end else if (model_misal(t, a)) begin
                if ({lsu_stall, lsu_misalign, dbus_req, lsu_wb_wen} !== 4'b0100)
                    $display("FAIL rnd_misal got stall=%b mis=%b req=%b wen=%b want 0 1 0 0 (type %0d addr %h)",
                             lsu_stall, lsu_misalign, dbus_req, lsu_wb_wen, t, a);
                else pass_cnt++;
                tick();
            end else begin
                if ({lsu_stall, dbus_req, lsu_misalign} !== 3'b100)
                    $display("FAIL rnd_idle got stall=%b req=%b mis=%b want 1 0 0", lsu_stall, dbus_req, lsu_misalign);
                else pass_cnt++;
                tick();
                for (int unsigned k = 0; k <= g; k++) begin
                    dbus_gnt = (k == g); dbus_rvalid = 1'($urandom_range(0, 1)); dbus_rdata = $urandom;
                    @(negedge clk);
                    chk_cnt++;
                    if ({dbus_req, dbus_we, lsu_stall, dbus_addr} !== {1'b1, st, 1'b1, a})
                        $display("FAIL rnd_req got req=%b we=%b stall=%b addr=%h want 1 %b 1 %h",
                                 dbus_req, dbus_we, lsu_stall, dbus_addr, st, a);
                    else pass_cnt++;
                    if (st) begin
                        chk_cnt++;
                        if ({dbus_wdata, dbus_wstrb} !== {model_wdata(t, d), model_wstrb(t, a)})
                            $display("FAIL rnd_store_fmt got wd=%h strb=%b want %h %b (type %0d addr %h)",
                                     dbus_wdata, dbus_wstrb, model_wdata(t, d), model_wstrb(t, a), t, a);
                        else pass_cnt++;
                    end
                    tick();
                end
                if (ld) begin
                    for (int unsigned k = 0; k <= r; k++) begin
                        dbus_gnt = 1'($urandom_range(0, 1)); dbus_rvalid = (k == r);
                        dbus_rdata = (k == r) ? rd : $urandom;
                        @(negedge clk);
                        chk_cnt++;
                        if ({dbus_req, lsu_stall} !== 2'b01)
                            $display("FAIL rnd_wait got req=%b stall=%b want 0 1", dbus_req, lsu_stall);
                        else pass_cnt++;
                        tick();
                    end
                end
                dbus_gnt = 1'($urandom_range(0, 1)); dbus_rvalid = 1'($urandom_range(0, 1)); dbus_rdata = $urandom;
                @(negedge clk);
                chk_cnt++;
                if ({lsu_stall, dbus_req, lsu_bus_err, lsu_wb_wen, lsu_wb_waddr} !== {3'b000, ld & w, wa})
                    $display("FAIL rnd_done got stall=%b req=%b err=%b wen=%b waddr=%0d want 0 0 0 %b %0d",
                             lsu_stall, dbus_req, lsu_bus_err, lsu_wb_wen, lsu_wb_waddr, ld & w, wa);
                else pass_cnt++;
                if (ld) begin
                    chk_cnt++;
                    if (lsu_wb_data !== model_load(t, a, rd, s))
                        $display("FAIL rnd_load_data got %h want %h (type %0d addr %h rdata %h sext %b)",
                                 lsu_wb_data, model_load(t, a, rd, s), t, a, rd, s);
                    else pass_cnt++;
                end
                tick();
            end
        end
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_lb();
        test_store_sh();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
